// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard/forwarding unit: scoreboard entry, select encoding, match helper.
// Entry fields are sized to the supported maxima so one struct serves every legal parameter set.
package hazard_pkg;

   localparam int MAX_REG_W = 8;
   localparam int MAX_SRC   = 4;
   localparam int SEL_W     = 4;
   localparam logic [SEL_W-1:0] FWD_RF = '0;

   typedef struct packed {
      logic                               valid;
      logic                               we;
      logic                               is_load;
      logic [MAX_REG_W-1:0]               dst;
      logic [MAX_SRC-1:0][MAX_REG_W-1:0]  src;
      logic [MAX_SRC-1:0]                 src_used;
   } sb_entry_t;

   // Register 0 never matches, so a zero source always reads the register file.
   function automatic logic src_match(input sb_entry_t p, input logic [MAX_REG_W-1:0] src,
                                      input logic used);
      return p.valid & p.we & used & (p.dst == src) & (p.dst != '0);
   endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-facing bundle of the hazard/forwarding unit: ID operands, stage results, EX operands, counters.
// master = pipeline side, slave = hazard unit.
interface hazard_fwd_unit_if #(
   parameter int XLEN    = 32,
   parameter int REG_W   = 5,
   parameter int DEPTH   = 3,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 32
);
   import hazard_pkg::*;

   logic                       id_valid;
   logic [NUM_SRC*REG_W-1:0]   id_src;
   logic [NUM_SRC-1:0]         id_src_used;
   logic [REG_W-1:0]           id_dst;
   logic                       id_we;
   logic                       id_is_load;
   logic                       flush;
   logic [DEPTH*XLEN-1:0]      stage_data;
   logic [NUM_SRC*XLEN-1:0]    ex_rf_data;
   logic                       clr_cnt;
   logic                       stall;
   logic [NUM_SRC*XLEN-1:0]    ex_fwd_data;
   logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel;
   logic                       hazard_err;
   logic [CNT_W-1:0]           stall_cnt;
   logic [CNT_W-1:0]           flush_cnt;
   logic [CNT_W-1:0]           fwd_cnt;

   modport master (
      output id_valid, id_src, id_src_used, id_dst, id_we, id_is_load,
             flush, stage_data, ex_rf_data, clr_cnt,
      input  stall, ex_fwd_data, ex_fwd_sel, hazard_err, stall_cnt, flush_cnt, fwd_cnt
   );

   modport slave (
      input  id_valid, id_src, id_src_used, id_dst, id_we, id_is_load,
             flush, stage_data, ex_rf_data, clr_cnt,
      output stall, ex_fwd_data, ex_fwd_sel, hazard_err, stall_cnt, flush_cnt, fwd_cnt
   );

endinterface

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// One EX operand: lowest-index producer in stages 1..DEPTH-1 wins, else register-file data.
// Purely combinational; err flags a pick whose load data is not yet available.
module fwd_mux
   import hazard_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 3,
   parameter int LOAD_RDY = 2
) (
   input  sb_entry_t [DEPTH-1:0]  sb,
   input  logic [MAX_REG_W-1:0]   src,
   input  logic                   src_used,
   input  logic [DEPTH*XLEN-1:0]  stage_data,
   input  logic [XLEN-1:0]        rf_data,
   output logic [XLEN-1:0]        fwd_data,
   output logic [SEL_W-1:0]       fwd_sel,
   output logic                   err
);

   logic found;

   always_comb begin
      fwd_data = rf_data;
      fwd_sel  = FWD_RF;
      err      = 1'b0;
      found    = 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
         if (!found && src_match(sb[k], src, src_used)) begin
            found    = 1'b1;
            fwd_data = stage_data[k*XLEN +: XLEN];
            fwd_sel  = SEL_W'(k);
            err      = sb[k].is_load && (k < LOAD_RDY);
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX operand forwarding driven by a shadow scoreboard of in-flight destinations.
// Stall and forwarding are combinational; scoreboard and saturating event counters update each edge.
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REG_W    = 5,
   parameter int DEPTH    = 3,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_RDY = 2,
   parameter int CNT_W    = 32
) (
   input logic               clk,
   input logic               rst_n,
   hazard_fwd_unit_if.slave  bus
);

   sb_entry_t [DEPTH-1:0]     sb_q, sb_d;
   sb_entry_t                 id_ent;
   logic                      load_hit;
   logic                      stall;
   logic                      insert;
   logic [NUM_SRC*XLEN-1:0]   fwd_data;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic [NUM_SRC-1:0]        err_vec;
   logic                      fwd_any;
   logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]          fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      id_ent                   = '0;
      id_ent.valid             = 1'b1;
      id_ent.we                = bus.id_we;
      id_ent.is_load           = bus.id_is_load;
      id_ent.dst[REG_W-1:0]    = bus.id_dst;
      for (int i = 0; i < NUM_SRC; i++) begin
         id_ent.src[i][REG_W-1:0] = bus.id_src[i*REG_W +: REG_W];
         id_ent.src_used[i]       = bus.id_src_used[i];
      end
   end

   // A load is usable only once it reaches stage LOAD_RDY, so stall while it would be reached too early.
   always_comb begin
      load_hit = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if ((s + 1 < LOAD_RDY) && sb_q[s].is_load &&
                src_match(sb_q[s], id_ent.src[i], id_ent.src_used[i]))
               load_hit = 1'b1;
         end
      end
   end

   assign stall  = bus.id_valid & ~bus.flush & load_hit;
   assign insert = bus.id_valid & ~stall & ~bus.flush;

   always_comb begin
      sb_d[0] = insert ? id_ent : '0;
      for (int k = 1; k < DEPTH; k++)
         sb_d[k] = sb_q[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sb_q <= '0;
      else
         sb_q <= sb_d;
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_mux #(
         .XLEN     (XLEN),
         .DEPTH    (DEPTH),
         .LOAD_RDY (LOAD_RDY)
      ) u_fwd_mux (
         .sb         (sb_q),
         .src        (sb_q[0].src[i]),
         .src_used   (sb_q[0].src_used[i]),
         .stage_data (bus.stage_data),
         .rf_data    (bus.ex_rf_data[i*XLEN +: XLEN]),
         .fwd_data   (fwd_data[i*XLEN +: XLEN]),
         .fwd_sel    (fwd_sel[i*SEL_W +: SEL_W]),
         .err        (err_vec[i])
      );
   end

   assign fwd_any = sb_q[0].valid & (|fwd_sel);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (bus.clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         fwd_cnt_d   = '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
         if (bus.flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
         if (fwd_any && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign bus.stall       = stall;
   assign bus.ex_fwd_data = fwd_data;
   assign bus.ex_fwd_sel  = fwd_sel;
   assign bus.hazard_err  = |err_vec;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;
   assign bus.fwd_cnt     = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with default geometry (DEPTH=3, LOAD_RDY=2) and 4-bit counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_fwd_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   passes;

   hazard_fwd_unit_if #(.CNT_W(4)) bus ();

   hazard_fwd_unit #(.CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst,
                         input logic we, input logic ld);
      bus.id_valid    = v;
      bus.id_src      = {s1, s0};
      bus.id_src_used = used;
      bus.id_dst      = dst;
      bus.id_we       = we;
      bus.id_is_load  = ld;
   endtask

   task automatic drain;
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      bus.flush      = 1'b0;
      bus.stage_data = '0;
      for (int i = 0; i < 3; i++) tick();
      bus.clr_cnt = 1'b1;
      tick();
      bus.clr_cnt = 1'b0;
   endtask

   task automatic test_reset;
      rst_n          = 1'b0;
      bus.flush      = 1'b0;
      bus.clr_cnt    = 1'b0;
      bus.stage_data = '0;
      bus.ex_rf_data = {32'hBBBB0001, 32'hAAAA0001};
      set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
      #2;
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall);
      else passes++;
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt, bus.fwd_cnt} !== 12'h000)
         $display("FAIL reset_cnt: got %h want 000", {bus.stall_cnt, bus.flush_cnt, bus.fwd_cnt});
      else passes++;
      checks++;
      if (bus.ex_fwd_sel !== 8'h00) $display("FAIL reset_sel: got %h want 00", bus.ex_fwd_sel);
      else passes++;
      checks++;
      if (bus.ex_fwd_data !== 64'hBBBB0001_AAAA0001)
         $display("FAIL reset_data: got %h want bbbb0001aaaa0001", bus.ex_fwd_data);
      else passes++;
      #5 rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.stall_cnt, bus.flush_cnt, bus.fwd_cnt} !== 12'h000)
         $display("FAIL post_reset_cnt: got %h want 000", {bus.stall_cnt, bus.flush_cnt, bus.fwd_cnt});
      else passes++;
   endtask

   task automatic test_alu_chain;
      drain();
      bus.ex_rf_data = {32'h0000BBBB, 32'h0000AAAA};
      set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0);
      sample();
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL alu_no_stall: got %b want 0", bus.stall);
      else passes++;
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      bus.stage_data = {32'h0, 32'h00001234, 32'h0};
      sample();
      checks++;
      if (bus.ex_fwd_sel !== 8'h01) $display("FAIL alu_sel: got %h want 01", bus.ex_fwd_sel);
      else passes++;
      checks++;
      if (bus.ex_fwd_data !== 64'h0000BBBB_00001234)
         $display("FAIL alu_data: got %h want 0000bbbb00001234", bus.ex_fwd_data);
      else passes++;
      tick();
      checks++;
      if (bus.fwd_cnt !== 4'd1) $display("FAIL alu_fwd_cnt: got %0d want 1", bus.fwd_cnt);
      else passes++;
   endtask

   task automatic test_load_use;
      drain();
      bus.ex_rf_data = {32'h00000B0B, 32'h00000A0A};
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
      sample();
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL lu_load_no_stall: got %b want 0", bus.stall);
      else passes++;
      tick();
      set_id(1'b1, 5'd8, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0);
      sample();
      checks++;
      if (bus.stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", bus.stall);
      else passes++;
      tick();
      sample();
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL lu_stall_one_cycle: got %b want 0", bus.stall);
      else passes++;
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      bus.stage_data = {32'hCAFEF00D, 32'h0, 32'h0};
      sample();
      checks++;
      if (bus.stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt);
      else passes++;
      checks++;
      if (bus.ex_fwd_sel !== 8'h02) $display("FAIL lu_sel: got %h want 02", bus.ex_fwd_sel);
      else passes++;
      checks++;
      if (bus.ex_fwd_data !== 64'h00000B0B_CAFEF00D)
         $display("FAIL lu_data: got %h want 00000b0bcafef00d", bus.ex_fwd_data);
      else passes++;
      checks++;
      if (bus.hazard_err !== 1'b0) $display("FAIL lu_err: got %b want 0", bus.hazard_err);
      else passes++;
   endtask

   task automatic test_priority_zero;
      drain();
      bus.ex_rf_data = {32'h0000BBBB, 32'h0000AAAA};
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);
      tick();
      tick();
      set_id(1'b1, 5'd7, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      bus.stage_data = {32'h00000022, 32'h00000011, 32'h0};
      sample();
      checks++;
      if (bus.ex_fwd_sel !== 8'h01) $display("FAIL prio_sel: got %h want 01", bus.ex_fwd_sel);
      else passes++;
      checks++;
      if (bus.ex_fwd_data !== 64'h0000BBBB_00000011)
         $display("FAIL prio_data: got %h want 0000bbbb00000011", bus.ex_fwd_data);
      else passes++;
      tick();
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
      sample();
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL zero_no_stall: got %b want 0", bus.stall);
      else passes++;
      tick();
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      bus.stage_data = {32'h00000022, 32'h00000011, 32'h0};
      sample();
      checks++;
      if (bus.ex_fwd_sel !== 8'h00) $display("FAIL zero_sel: got %h want 00", bus.ex_fwd_sel);
      else passes++;
      checks++;
      if (bus.ex_fwd_data !== 64'h0000BBBB_0000AAAA)
         $display("FAIL zero_data: got %h want 0000bbbb0000aaaa", bus.ex_fwd_data);
      else passes++;
   endtask

   task automatic test_flush_stall;
      drain();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd4, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
      bus.flush = 1'b1;
      sample();
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", bus.stall);
      else passes++;
      tick();
      bus.flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      sample();
      checks++;
      if (bus.flush_cnt !== 4'd1) $display("FAIL flush_cnt: got %0d want 1", bus.flush_cnt);
      else passes++;
      checks++;
      if (bus.stall_cnt !== 4'd0) $display("FAIL flush_stall_cnt: got %0d want 0", bus.stall_cnt);
      else passes++;
      checks++;
      if ({bus.hazard_err, bus.ex_fwd_sel} !== 9'h000)
         $display("FAIL flush_bubble: got err/sel %h want 000", {bus.hazard_err, bus.ex_fwd_sel});
      else passes++;
   endtask

   task automatic test_saturation;
      drain();
      set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd10, 1'b1, 1'b1);
      for (int i = 0; i < 41; i++) tick();
      bus.clr_cnt = 1'b1;
      sample();
      checks++;
      if (bus.stall_cnt !== 4'hF) $display("FAIL sat_stall_cnt: got %0d want 15", bus.stall_cnt);
      else passes++;
      checks++;
      if (bus.stall !== 1'b1) $display("FAIL sat_stall_with_clr: got %b want 1", bus.stall);
      else passes++;
      tick();
      bus.clr_cnt = 1'b0;
      checks++;
      if (bus.stall_cnt !== 4'd0) $display("FAIL clr_priority: got %0d want 0", bus.stall_cnt);
      else passes++;
   endtask

   task automatic test_reset_mid;
      drain();
      set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd8, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
      sample();
      checks++;
      if (bus.stall !== 1'b1) $display("FAIL mid_pre_stall: got %b want 1", bus.stall);
      else passes++;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0) $display("FAIL mid_async_stall: got %b want 0", bus.stall);
      else passes++;
      #1 rst_n = 1'b1;
      tick();
      sample();
      checks++;
      if ({bus.stall, bus.stall_cnt} !== 5'h00)
         $display("FAIL mid_after: got stall/cnt %h want 00", {bus.stall, bus.stall_cnt});
      else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_priority_zero();
      test_flush_stall();
      test_saturation();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
